// File: rtl/bus_arbiter.sv
// Round-robin arbiter for users sharing one 3-state bus: one-hot-or-zero
// grant, one-cycle turnaround between owners, and a slice limit under contention.
module bus_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] en,
  output logic [2:0]   owner,
  output logic         busy,
  output logic         turn
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    en_q, en_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_nxt;
  logic [PW-1:0]   cand;
  logic            others;

  // State register; reset drops the grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round-robin search: first requester at or after ptr, wrapping mod N
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_nxt = '0;
    cand    = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = PW'((int'(ptr_q) + i) % int'(N));
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_nxt = PW'((int'(win) + 1) % int'(N));
  end

  // Any requester other than the current owner (en_q is one-hot in GRANT)
  assign others = |(req & ~en_q);

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        en_d = '0;
        if (found) begin
          en_d    = N'(1) << win;
          owner_d = win;
          ptr_d   = win_nxt;
          cnt_d   = CW'(1);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          en_d    = '0;
          state_d = ST_TURN;
        end else if (cnt_q == CW'(SLICE)) begin
          if (others) begin
            en_d    = '0;
            state_d = ST_TURN;
          end else begin
            cnt_d = CW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        en_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from registers; no path from req
  always_comb begin
    en    = en_q;
    owner = 3'(owner_q);
    busy  = |en_q;
    turn  = (state_q == ST_TURN);
  end

endmodule
